// File: rtl/axil_bram_ctrl.sv
// AXI4-Lite slave driving a single-port BRAM (1-cycle read latency), one transaction at a time.
// Optional macro AXIL_BRAM_RANGE_CHECK_EN: out-of-range addresses answer SLVERR without touching the BRAM.
module axil_bram_ctrl #(
  parameter int unsigned MEM_DATA_WIDTH  = 32,
  parameter int unsigned BRAM_ADDR_WIDTH = 5,
  parameter int unsigned AXI_ADDR_WIDTH  = 32
) (
  input  logic                          clka,
  input  logic                          rsta,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [MEM_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [MEM_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [MEM_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic [BRAM_ADDR_WIDTH-1:0]    bram_addra,
  output logic                          bram_ena,
  output logic [MEM_DATA_WIDTH/8-1:0]   bram_wea,
  output logic [MEM_DATA_WIDTH-1:0]     bram_dina,
  input  logic [MEM_DATA_WIDTH-1:0]     bram_douta
);

  localparam int unsigned STRB_W = MEM_DATA_WIDTH / 8;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_CAPTURE, RD_RESP
  } state_e;

  state_e                      state_q, state_d;
  logic                        last_wr_q, last_wr_d;
  logic                        err_q, err_d;
  logic                        ena_q, ena_d;
  logic [STRB_W-1:0]           wea_q, wea_d;
  logic [BRAM_ADDR_WIDTH-1:0]  addra_q, addra_d;
  logic [MEM_DATA_WIDTH-1:0]   dina_q, dina_d;
  logic                        bvalid_q, bvalid_d;
  logic [1:0]                  bresp_q, bresp_d;
  logic                        rvalid_q, rvalid_d;
  logic [MEM_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]                  rresp_q, rresp_d;

  logic wr_elig, rd_elig, grant_wr, grant_rd;
  logic aw_oob, ar_oob;

`ifdef AXIL_BRAM_RANGE_CHECK_EN
  assign aw_oob = |(s_axi_awaddr >> BRAM_ADDR_WIDTH);
  assign ar_oob = |(s_axi_araddr >> BRAM_ADDR_WIDTH);
`else
  assign aw_oob = 1'b0;
  assign ar_oob = 1'b0;
`endif

  // Upper address bits only matter when the range check is built in
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

  // Round-robin arbitration between a complete write (AW+W) and a read, only in IDLE
  always_comb begin
    wr_elig  = s_axi_awvalid && s_axi_wvalid;
    rd_elig  = s_axi_arvalid;
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    if (state_q == IDLE) begin
      grant_rd = rd_elig && (!wr_elig || last_wr_q);
      grant_wr = wr_elig && !grant_rd;
    end
  end

  assign s_axi_awready = grant_wr;
  assign s_axi_wready  = grant_wr;
  assign s_axi_arready = grant_rd;

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    err_d     = err_q;
    ena_d     = 1'b0;
    wea_d     = '0;
    addra_d   = addra_q;
    dina_d    = dina_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (state_q)
      IDLE: begin
        if (grant_wr) begin
          state_d   = WR_ISSUE;
          last_wr_d = 1'b1;
          err_d     = aw_oob;
          ena_d     = !aw_oob;
          wea_d     = aw_oob ? '0 : s_axi_wstrb;
          addra_d   = s_axi_awaddr[BRAM_ADDR_WIDTH-1:0];
          dina_d    = s_axi_wdata;
        end else if (grant_rd) begin
          state_d   = RD_ISSUE;
          last_wr_d = 1'b0;
          err_d     = ar_oob;
          ena_d     = !ar_oob;
          addra_d   = s_axi_araddr[BRAM_ADDR_WIDTH-1:0];
        end
      end
      WR_ISSUE: begin
        state_d  = WR_RESP;
        bvalid_d = 1'b1;
        bresp_d  = err_q ? SLVERR : OKAY;
      end
      WR_RESP: begin
        if (s_axi_bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      RD_ISSUE: state_d = RD_CAPTURE;
      RD_CAPTURE: begin
        state_d  = RD_RESP;
        rdata_d  = err_q ? '0 : bram_douta;
        rvalid_d = 1'b1;
        rresp_d  = err_q ? SLVERR : OKAY;
      end
      RD_RESP: begin
        if (s_axi_rready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b1;
      err_q     <= 1'b0;
      ena_q     <= 1'b0;
      wea_q     <= '0;
      addra_q   <= '0;
      dina_q    <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      err_q     <= err_d;
      ena_q     <= ena_d;
      wea_q     <= wea_d;
      addra_q   <= addra_d;
      dina_q    <= dina_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign bram_ena     = ena_q;
  assign bram_wea     = wea_q;
  assign bram_addra   = addra_q;
  assign bram_dina    = dina_q;
  assign s_axi_bvalid = bvalid_q;
  assign s_axi_bresp  = bresp_q;
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = rresp_q;

endmodule
